// File: rtl/vector_response_checker.sv
// End-of-run response checker: compares each accepted DUT response against a
// loadable expected-vector memory and reports the mismatch count, the first
// failing index and a pass flag.
module vector_response_checker #(
  parameter int OUTPUT_WIDTH    = 1,
  parameter int NUMBER_OF_TESTS = 4,
  parameter int INDEX_WIDTH     = 2,
  parameter int COUNT_WIDTH     = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load_en,
  input  logic [INDEX_WIDTH-1:0]  load_addr,
  input  logic [OUTPUT_WIDTH-1:0] load_data,
  input  logic                    start,
  input  logic                    resp_valid,
  input  logic [OUTPUT_WIDTH-1:0] resp_data,
  output logic                    resp_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    pass,
  output logic [COUNT_WIDTH-1:0]  mismatch_count,
  output logic                    first_fail_valid,
  output logic [INDEX_WIDTH-1:0]  first_fail_index,
  output logic                    mismatch_pulse
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  localparam logic [INDEX_WIDTH:0]   LP_NUM_TESTS = (INDEX_WIDTH+1)'(NUMBER_OF_TESTS);
  localparam logic [INDEX_WIDTH-1:0] LP_LAST_IDX  = INDEX_WIDTH'(NUMBER_OF_TESTS - 1);

  state_t                  r_state;
  logic [INDEX_WIDTH-1:0]  r_index;
  logic [COUNT_WIDTH-1:0]  r_count;
  logic                    r_ff_valid;
  logic [INDEX_WIDTH-1:0]  r_ff_index;
  logic                    r_pulse;

  // Sized to the full index range so any r_index value is a legal read.
  logic [OUTPUT_WIDTH-1:0] r_mem [2**INDEX_WIDTH];

  logic w_accept;
  logic w_mismatch;
  logic w_load;

  assign w_accept   = (r_state == ST_RUN) && resp_valid;
  assign w_mismatch = (resp_data != r_mem[r_index]);
  assign w_load     = load_en && (r_state != ST_RUN) && ({1'b0, load_addr} < LP_NUM_TESTS);

  // Expected-vector memory is intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_load) begin
      r_mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= ST_IDLE;
      r_index    <= '0;
      r_count    <= '0;
      r_ff_valid <= 1'b0;
      r_ff_index <= '0;
      r_pulse    <= 1'b0;
    end else begin
      r_pulse <= 1'b0;
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_state    <= ST_RUN;
            r_index    <= '0;
            r_count    <= '0;
            r_ff_valid <= 1'b0;
            r_ff_index <= '0;
          end
        end
        ST_RUN: begin
          if (w_accept) begin
            if (w_mismatch) begin
              r_pulse <= 1'b1;
              if (r_count != '1) begin
                r_count <= r_count + COUNT_WIDTH'(1);
              end
              if (!r_ff_valid) begin
                r_ff_valid <= 1'b1;
                r_ff_index <= r_index;
              end
            end
            if (r_index == LP_LAST_IDX) begin
              r_index <= '0;
              r_state <= ST_DONE;
            end else begin
              r_index <= r_index + INDEX_WIDTH'(1);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign resp_ready       = (r_state == ST_RUN);
  assign busy             = (r_state == ST_RUN);
  assign done             = (r_state == ST_DONE);
  assign pass             = (r_state == ST_DONE) && (r_count == '0);
  assign mismatch_count   = r_count;
  assign first_fail_valid = r_ff_valid;
  assign first_fail_index = r_ff_index;
  assign mismatch_pulse   = r_pulse;

endmodule

// File: tb/tb_vector_response_checker.sv
// Scoreboard bench for vector_response_checker: stimulus queues hand-computed
// per-accept pulse and end-of-run results; a negedge monitor pops and compares.
module tb_vector_response_checker;

  logic       clk = 1'b0;
  logic       rst;
  logic       load_en;
  logic [1:0] load_addr;
  logic [0:0] load_data;
  logic       start;
  logic       resp_valid;
  logic [0:0] resp_data;
  logic       resp_ready;
  logic       busy;
  logic       done;
  logic       pass;
  logic [1:0] mismatch_count;
  logic       first_fail_valid;
  logic [1:0] first_fail_index;
  logic       mismatch_pulse;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic       pass;
    logic [1:0] cnt;
    logic       ffv;
    logic [1:0] ffi;
    int         rdy;
  } res_t;

  logic q_pulse[$];
  res_t q_res[$];

  vector_response_checker #(
    .OUTPUT_WIDTH   (1),
    .NUMBER_OF_TESTS(4),
    .INDEX_WIDTH    (2),
    .COUNT_WIDTH    (2)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .load_en         (load_en),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .start           (start),
    .resp_valid      (resp_valid),
    .resp_data       (resp_data),
    .resp_ready      (resp_ready),
    .busy            (busy),
    .done            (done),
    .pass            (pass),
    .mismatch_count  (mismatch_count),
    .first_fail_valid(first_fail_valid),
    .first_fail_index(first_fail_index),
    .mismatch_pulse  (mismatch_pulse)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [1:0] a, input logic d);
    load_en = 1'b1; load_addr = a; load_data = d;
    tick();
    load_en = 1'b0;
  endtask

  task automatic start_run();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic send(input logic v, input int gap, input logic exp_pulse);
    resp_valid = 1'b0;
    repeat (gap) tick();
    q_pulse.push_back(exp_pulse);
    resp_valid = 1'b1;
    resp_data  = v;
    tick();
    resp_valid = 1'b0;
  endtask

  // v[i]/p[i] are the response and expected pulse for index i; gaps 4 bits each.
  task automatic run4(input logic [3:0] v, input logic [3:0] p, input logic [15:0] gaps);
    for (int i = 0; i < 4; i++) begin
      send(v[i], int'(gaps[4*i +: 4]), p[i]);
    end
    tick();
  endtask

  task automatic expect_res(input logic ps, input logic [1:0] cnt, input logic ffv,
                            input logic [1:0] ffi, input int rdy);
    res_t r;
    r.pass = ps; r.cnt = cnt; r.ffv = ffv; r.ffi = ffi; r.rdy = rdy;
    q_res.push_back(r);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_ready"}, int'(resp_ready), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_count"}, int'(mismatch_count), 0);
    chk({tag, "_ffv"}, int'(first_fail_valid), 0);
    chk({tag, "_ffi"}, int'(first_fail_index), 0);
    chk({tag, "_pulse"}, int'(mismatch_pulse), 0);
  endtask

  task automatic check_cleared(input string tag);
    chk({tag, "_busy"}, int'(busy), 1);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_count"}, int'(mismatch_count), 0);
    chk({tag, "_ffv"}, int'(first_fail_valid), 0);
    chk({tag, "_ffi"}, int'(first_fail_index), 0);
  endtask

  // Monitor: an accept seen at one negedge must show its pulse at the next.
  initial begin
    logic pend   = 1'b0;
    logic done_q = 1'b0;
    int   rdy    = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        pend = 1'b0; done_q = 1'b0; rdy = 0;
      end else begin
        if (pend) begin
          if (q_pulse.size() == 0) chk("pulse_queue_underflow", 1, 0);
          else chk("mismatch_pulse", int'(mismatch_pulse), int'(q_pulse.pop_front()));
        end else if (mismatch_pulse) begin
          chk("unexpected_mismatch_pulse", 1, 0);
        end
        pend = resp_valid && resp_ready;
        if (resp_ready) rdy++;
        if (done && !done_q) begin
          if (q_res.size() == 0) begin
            chk("unexpected_done", 1, 0);
          end else begin
            res_t r;
            r = q_res.pop_front();
            chk("res_pass", int'(pass), int'(r.pass));
            chk("res_count", int'(mismatch_count), int'(r.cnt));
            chk("res_ffv", int'(first_fail_valid), int'(r.ffv));
            chk("res_ffi", int'(first_fail_index), int'(r.ffi));
            chk("res_ready_cycles", rdy, r.rdy);
          end
          rdy = 0;
        end
        done_q = done;
      end
    end
  end

  initial begin
    repeat (5000) @(posedge clk);
    $display("FAIL watchdog: simulation exceeded cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; load_en = 1'b0; load_addr = '0; load_data = '0;
    start = 1'b0; resp_valid = 1'b0; resp_data = '0;
    tick(); tick();
    check_quiet("reset");
    rst = 1'b0;
    tick();

    // Expected {0,1,1,0}; final write coincides with start.
    load(2'd0, 1'b0);
    load(2'd1, 1'b1);
    load(2'd2, 1'b1);
    load_en = 1'b1; load_addr = 2'd3; load_data = 1'b0; start = 1'b1;
    tick();
    load_en = 1'b0; start = 1'b0;
    expect_res(1'b1, 2'd0, 1'b0, 2'd0, 4);
    run4(4'b0110, 4'b0000, 16'h0000);

    // Stream 0,0,1,1: mismatches at index 1 and 3.
    start_run();
    expect_res(1'b0, 2'd2, 1'b1, 2'd1, 4);
    run4(4'b1100, 4'b1010, 16'h0000);

    // Gaps 0/3/1 between vectors; results clear on restart from DONE.
    start_run();
    check_cleared("restart_clear");
    expect_res(1'b1, 2'd0, 1'b0, 2'd0, 8);
    run4(4'b0110, 4'b0000, 16'h1300);

    // Reset after two accepts aborts the run; memory survives.
    start_run();
    send(1'b0, 0, 1'b0);
    send(1'b1, 0, 1'b0);
    tick();
    rst = 1'b1;
    #2;
    check_quiet("midrun_reset");
    tick();
    rst = 1'b0;
    tick();
    start_run();
    expect_res(1'b1, 2'd0, 1'b0, 2'd0, 4);
    run4(4'b0110, 4'b0000, 16'h0000);

    // All-mismatch stream saturates the 2-bit counter at 3.
    start_run();
    expect_res(1'b0, 2'd3, 1'b1, 2'd0, 4);
    run4(4'b1001, 4'b1111, 16'h0000);

    // load_en during RUN is ignored: index 3 still expects 0.
    start_run();
    check_cleared("restart_clear2");
    expect_res(1'b1, 2'd0, 1'b0, 2'd0, 4);
    load_en = 1'b1; load_addr = 2'd3; load_data = 1'b1;
    send(1'b0, 0, 1'b0);
    send(1'b1, 0, 1'b0);
    send(1'b1, 0, 1'b0);
    load_en = 1'b0;
    send(1'b0, 0, 1'b0);
    tick();
    start_run();
    expect_res(1'b1, 2'd0, 1'b0, 2'd0, 4);
    run4(4'b0110, 4'b0000, 16'h0000);

    repeat (3) tick();
    chk("pulse_queue_drained", q_pulse.size(), 0);
    chk("result_queue_drained", q_res.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
